// File: rtl/mux4_sel_reg_if.sv
// Bus bundle for mux4_sel_reg: four data inputs, a 2-bit select and a capture enable.
// The result comes back with a valid flag.
interface mux4_sel_reg_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [1:0]       select;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (
        output a, b, c, d, select, in_valid,
        input  out, out_valid
    );

    modport slave (
        input  a, b, c, d, select, in_valid,
        output out, out_valid
    );
endinterface

// File: rtl/mux4_sel_reg.sv
// Four-way mux with a 2-bit select.
// The output is registered with one cycle of latency, or purely combinational when REGISTERED=0.
module mux4_sel_reg #(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    mux4_sel_reg_if.slave  bus
);

    logic [WIDTH-1:0] mux_out;

    // NOTE: an unknown select yields all-X rather than quietly falling back to a.
    always_comb begin
        mux_out = bus.a;
        case (bus.select)
            2'b00:   mux_out = bus.a;
            2'b01:   mux_out = bus.b;
            2'b10:   mux_out = bus.c;
            2'b11:   mux_out = bus.d;
            default: mux_out = 'x;
        endcase
    end

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] out_q;
            logic             valid_q;

            // NOTE: state uses non-blocking assignments; the data register is reset
            // so that out reads 0 during and right after reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= bus.in_valid;
                    if (bus.in_valid) begin
                        out_q <= mux_out;
                    end
                end
            end

            assign bus.out       = out_q;
            assign bus.out_valid = valid_q;
        end else begin : g_bypass
            assign bus.out       = mux_out;
            assign bus.out_valid = bus.in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_mux4_sel_reg.sv
// Self-checking bench for mux4_sel_reg.
// It drives registered WIDTH=1 and WIDTH=8 instances and a bypass instance in lockstep.
module tb_mux4_sel_reg;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    // Reference state for the registered instances (8-bit view; the 1-bit DUT sees bit 0).
    logic [7:0] exp_out;
    logic       exp_valid;

    mux4_sel_reg_if #(.WIDTH(1)) if1 ();
    mux4_sel_reg_if #(.WIDTH(8)) if8 ();
    mux4_sel_reg_if #(.WIDTH(1)) ifb ();

    mux4_sel_reg #(.WIDTH(1), .REGISTERED(1'b1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mux4_sel_reg #(.WIDTH(8), .REGISTERED(1'b1)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    mux4_sel_reg #(.WIDTH(1), .REGISTERED(1'b0)) u_byp (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pick(input logic [7:0] a, b, c, d, input logic [1:0] sel);
        logic [7:0] tbl [4];
        tbl = '{a, b, c, d};
        return tbl[sel];
    endfunction

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_w1_out"},   {7'b0, if1.out},       {7'b0, exp_out[0]});
        check({tag, "_w1_valid"}, {7'b0, if1.out_valid}, {7'b0, exp_valid});
        check({tag, "_w8_out"},   if8.out,               exp_out);
        check({tag, "_w8_valid"}, {7'b0, if8.out_valid}, {7'b0, exp_valid});
    endtask

    // Apply one input set just after an edge, check bypass, then check registered outputs after the next edge.
    task automatic step(input string tag, input logic [7:0] a, b, c, d,
                        input logic [1:0] sel, input logic iv);
        logic [7:0] v;
        if8.a = a; if8.b = b; if8.c = c; if8.d = d; if8.select = sel; if8.in_valid = iv;
        if1.a = a[0]; if1.b = b[0]; if1.c = c[0]; if1.d = d[0]; if1.select = sel; if1.in_valid = iv;
        ifb.a = a[0]; ifb.b = b[0]; ifb.c = c[0]; ifb.d = d[0]; ifb.select = sel; ifb.in_valid = iv;
        v = pick(a, b, c, d, sel);
        #1;
        check({tag, "_byp_out"},   {7'b0, ifb.out},       {7'b0, v[0]});
        check({tag, "_byp_valid"}, {7'b0, ifb.out_valid}, {7'b0, iv});
        @(posedge clk);
        if (!rst_n) begin
            exp_out   = '0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = iv;
            if (iv) exp_out = v;
        end
        #1;
        check_regs(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_out     = '0;
        exp_valid   = 1'b0;
        rst_n       = 1'b0;
        if8.a = '0; if8.b = '0; if8.c = '0; if8.d = '0; if8.select = '0; if8.in_valid = 1'b0;
        if1.a = '0; if1.b = '0; if1.c = '0; if1.d = '0; if1.select = '0; if1.in_valid = 1'b0;
        ifb.a = '0; ifb.b = '0; ifb.c = '0; ifb.d = '0; ifb.select = '0; ifb.in_valid = 1'b0;

        // Reset state
        #3;
        check_regs("reset");
        @(posedge clk);
        #1;
        check_regs("reset_hold");
        rst_n = 1'b1;

        // One-hot decode
        for (int hot = 0; hot < 4; hot++) begin
            for (int s = 0; s < 4; s++) begin
                step("decode",
                     (hot == 0) ? 8'hFF : 8'h00, (hot == 1) ? 8'hFF : 8'h00,
                     (hot == 2) ? 8'hFF : 8'h00, (hot == 3) ? 8'hFF : 8'h00,
                     s[1:0], 1'b1);
            end
        end

        // Capture a 1, then assert reset mid-cycle
        step("pre_rst", 8'hFF, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);
        #2;
        rst_n = 1'b0;
        exp_out   = '0;
        exp_valid = 1'b0;
        #1;
        check_regs("async_rst");
        // Reset wins over a capture on the same edge
        step("rst_vs_cap", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'b10, 1'b1);
        step("rst_hold", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'b01, 1'b1);
        rst_n = 1'b1;
        step("release", 8'h00, 8'h00, 8'h00, 8'hFF, 2'b11, 1'b1);

        // Hold: capture c, then in_valid low while c toggles
        step("hold_cap", 8'h00, 8'h00, 8'hFF, 8'h00, 2'b10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("hold", 8'h00, 8'h00, (i % 2 == 0) ? 8'h00 : 8'hFF, 8'h00, 2'b10, 1'b0);
        end
        // Changes between edges never reach the registered output
        if8.c = 8'h5A;
        if1.c = 1'b0;
        #2;
        check_regs("mid_cycle");

        // WIDTH=8 patterns
        step("w8_sel3", 8'hA5, 8'h3C, 8'hF0, 8'h0F, 2'b11, 1'b1);
        step("w8_sel1", 8'hA5, 8'h3C, 8'hF0, 8'h0F, 2'b01, 1'b1);

        // Bypass follows in_valid and data with no clock edge
        ifb.select = 2'b01; ifb.b = 1'b1; ifb.a = 1'b0; ifb.in_valid = 1'b0;
        #1;
        check("byp_nclk_out",   {7'b0, ifb.out},       8'h01);
        check("byp_nclk_v0",    {7'b0, ifb.out_valid}, 8'h00);
        ifb.in_valid = 1'b1;
        #1;
        check("byp_nclk_v1",    {7'b0, ifb.out_valid}, 8'h01);
        @(posedge clk);
        #1;

        // Random back-to-back stress
        for (int i = 0; i < 20; i++) begin
            step("random", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
